// File: rtl/bls_csa_pkg.sv
// Shared defaults, FSM state type and sizing helper for the BLS12-381
// carry-save multi-operand accumulator.
package bls_csa_pkg;

    localparam int BIT_LEN_DEF  = 381;
    localparam int EXT_BITS_DEF = 4;
    localparam int CHUNK_DEF    = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        RESOLVE,
        DONE
    } csa_acc_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/csa_row.sv
// Vector 3:2 compressor: per-bit XOR sum and majority, purely combinational.
module csa_row #(
    parameter int W = 23
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] maj
);

    assign sum = a ^ b ^ c;
    assign maj = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accumulator.sv
// Streaming carry-save accumulator with chunked carry-propagate resolve.
// Optional overflow flag output enabled by defining CSA_ACC_OVF_EN.
module csa_accumulator
    import bls_csa_pkg::*;
#(
    parameter int BIT_LEN  = BIT_LEN_DEF,
    parameter int EXT_BITS = EXT_BITS_DEF,
    parameter int CHUNK    = CHUNK_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BIT_LEN-1:0]          in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
`ifdef CSA_ACC_OVF_EN
    output logic                        out_ovf,
`endif
    output logic [BIT_LEN+EXT_BITS-1:0] out_sum
);

    localparam int W        = BIT_LEN + EXT_BITS;
    localparam int NCHUNK   = ceil_div(W, CHUNK);
    localparam int WP       = NCHUNK * CHUNK;
    localparam int TOP_BITS = W - (NCHUNK - 1) * CHUNK;
    localparam int IDXW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    csa_acc_state_t state, state_n;

    logic [W-1:0]    s_acc, c_acc, x_ext, row_sum, row_maj, sum_n;
    logic [WP-1:0]   s_pad, c_pad;
    logic [IDXW-1:0] idx;
    logic [CHUNK:0]  slice_sum;
    logic            carry, rdy_q, accept, last_slice;

    assign x_ext      = W'(in_data);
    assign s_pad      = WP'(s_acc);
    assign c_pad      = WP'(c_acc);
    assign accept     = in_valid & rdy_q;
    assign in_ready   = rdy_q;
    assign out_valid  = (state == DONE);
    assign last_slice = (idx == LAST_IDX);

    csa_row #(.W(W)) u_row (
        .a   (s_acc),
        .b   (c_acc),
        .c   (x_ext),
        .sum (row_sum),
        .maj (row_maj)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, ACC: if (accept) state_n = in_last ? RESOLVE : ACC;
            RESOLVE:   if (last_slice) state_n = DONE;
            DONE:      if (out_ready) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // in_ready is derived from the next state so it never depends on out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rdy_q <= 1'b0;
        end else begin
            state <= state_n;
            rdy_q <= (state_n == IDLE) || (state_n == ACC);
        end
    end

    // One CHUNK-wide slice of S + C + carry per resolve cycle
    always_comb begin
        int base;
        base      = int'(idx) * CHUNK;
        slice_sum = {1'b0, s_pad[base +: CHUNK]} + {1'b0, c_pad[base +: CHUNK]}
                  + (CHUNK+1)'(carry);
        sum_n     = out_sum;
        for (int i = 0; i < W; i++) begin
            if (i / CHUNK == int'(idx)) sum_n[i] = slice_sum[i % CHUNK];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_acc   <= '0;
            c_acc   <= '0;
            out_sum <= '0;
            idx     <= '0;
            carry   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    s_acc <= x_ext;
                    c_acc <= '0;
                end
                ACC: if (accept) begin
                    s_acc <= row_sum;
                    c_acc <= row_maj << 1;
                end
                RESOLVE: begin
                    out_sum <= sum_n;
                    carry   <= last_slice ? 1'b0 : slice_sum[CHUNK];
                    idx     <= last_slice ? '0 : idx + 1'b1;
                end
                DONE: if (out_ready) begin
                    s_acc <= '0;
                    c_acc <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef CSA_ACC_OVF_EN
    localparam logic [EXT_BITS:0] CNT_LIM = {1'b1, {EXT_BITS{1'b0}}};

    logic [EXT_BITS:0] cnt;
    logic              ovf_q, top_carry;

    function automatic logic [EXT_BITS:0] sat_inc(input logic [EXT_BITS:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Carry out of bit W-1 in the clipped top slice is the wrap indicator
    assign top_carry = slice_sum[TOP_BITS];
    assign out_ovf   = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (accept) cnt <= sat_inc(cnt);
            if (state == RESOLVE && last_slice) ovf_q <= (cnt > CNT_LIM) | top_carry;
            if (state == DONE && out_ready) begin
                cnt   <= '0;
                ovf_q <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed testbench for csa_accumulator at BIT_LEN=19, EXT_BITS=4, CHUNK=8.
module tb_csa_accumulator;

    localparam int BIT_LEN  = 19;
    localparam int EXT_BITS = 4;
    localparam int CHUNK    = 8;
    localparam int W        = BIT_LEN + EXT_BITS;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [BIT_LEN-1:0] in_data = '0;
    logic               in_last = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [W-1:0]       out_sum;
`ifdef CSA_ACC_OVF_EN
    logic               out_ovf;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csa_accumulator #(
        .BIT_LEN  (BIT_LEN),
        .EXT_BITS (EXT_BITS),
        .CHUNK    (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef CSA_ACC_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .out_sum   (out_sum)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and hold it until the handshake edge has passed
    task automatic send(input logic [BIT_LEN-1:0] d, input logic last);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready: got %b required 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b required 0", out_valid);
        end
        checks++;
        if (out_sum !== 23'h0) begin
            failures++;
            $display("FAIL reset_out_sum: got %h required 000000", out_sum);
        end
`ifdef CSA_ACC_OVF_EN
        checks++;
        if (out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_ovf: got %b required 0", out_ovf);
        end
`endif
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_cycle_in_ready: got %b required 0", in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_three_operands();
        int n;
        send(19'h457ED, 1'b0);
        send(19'h5F78C, 1'b0);
        send(19'h5E9F9, 1'b1);
        wait_valid(n);
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL three_latency: got %0d cycles required 3", n);
        end
        checks++;
        if (out_sum !== 23'h103972) begin
            failures++;
            $display("FAIL three_sum: got %h required 103972", out_sum);
        end
        release_result();
    endtask

    task automatic test_single();
        int n;
        send(19'h7FFFF, 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL single_resolve_in_ready: got %b required 0", in_ready);
            end
            tick();
            n++;
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL single_latency: got %0d cycles required 3", n);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_done_in_ready: got %b required 0", in_ready);
        end
        checks++;
        if (out_sum !== 23'h07FFFF) begin
            failures++;
            $display("FAIL single_sum: got %h required 07ffff", out_sum);
        end
        release_result();
    endtask

    task automatic test_wrap();
        int n;
        for (int i = 0; i < 16; i++) send(19'h7FFFF, (i == 15));
        wait_valid(n);
        checks++;
        if (out_sum !== 23'h7FFFF0) begin
            failures++;
            $display("FAIL sixteen_sum: got %h required 7ffff0", out_sum);
        end
`ifdef CSA_ACC_OVF_EN
        checks++;
        if (out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL sixteen_ovf: got %b required 0", out_ovf);
        end
`endif
        release_result();
        for (int i = 0; i < 17; i++) send(19'h7FFFF, (i == 16));
        wait_valid(n);
        checks++;
        if (out_sum !== 23'h07FFEF) begin
            failures++;
            $display("FAIL seventeen_sum: got %h required 07ffef", out_sum);
        end
`ifdef CSA_ACC_OVF_EN
        checks++;
        if (out_ovf !== 1'b1) begin
            failures++;
            $display("FAIL seventeen_ovf: got %b required 1", out_ovf);
        end
`endif
        release_result();
    endtask

    task automatic test_backpressure();
        int n;
        send(19'h00005, 1'b1);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 19'h12345;
            in_last  = 1'b1;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sum !== 23'h000005) begin
                failures++;
                $display("FAIL backpressure_hold: valid=%b sum=%h required 1 000005",
                         out_valid, out_sum);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        release_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release: valid=%b ready=%b required 0 1",
                     out_valid, in_ready);
        end
        send(19'h00002, 1'b1);
        wait_valid(n);
        checks++;
        if (out_sum !== 23'h000002) begin
            failures++;
            $display("FAIL backpressure_followup: got %h required 000002", out_sum);
        end
        release_result();
    endtask

    task automatic test_bubbles();
        int n;
        send(19'h457ED, 1'b0);
        tick();
        send(19'h5F78C, 1'b0);
        tick();
        tick();
        send(19'h5E9F9, 1'b1);
        wait_valid(n);
        checks++;
        if (out_sum !== 23'h103972) begin
            failures++;
            $display("FAIL bubbles_sum: got %h required 103972", out_sum);
        end
        release_result();
    endtask

    task automatic test_reset_resolve();
        int n;
        send(19'h457ED, 1'b0);
        send(19'h5F78C, 1'b0);
        send(19'h5E9F9, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_sum !== 23'h0) begin
            failures++;
            $display("FAIL midresolve_reset: valid=%b ready=%b sum=%h required 0 0 000000",
                     out_valid, in_ready, out_sum);
        end
        send(19'h00001, 1'b1);
        wait_valid(n);
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL midresolve_latency: got %0d cycles required 3", n);
        end
        checks++;
        if (out_sum !== 23'h000001) begin
            failures++;
            $display("FAIL midresolve_sum: got %h required 000001", out_sum);
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_three_operands();
        test_single();
        test_wrap();
        test_backpressure();
        test_bubbles();
        test_reset_resolve();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
